// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: a byte FIFO feeding a START/DATA/PARITY/STOP
// serialiser whose baud and parity settings are captured when each byte is popped.
module uart_tx_frame_gen #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic                          cfg_en,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic [7:0]                    cfg_br,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [11:0]     width_cnt_q, width_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      br_q, br_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_bit_q, par_bit_d;
  logic            uart_tx_q, uart_tx_d;
  logic            tx_done_q, tx_done_d;
  logic            push, pop, bit_end, full, empty;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push    = tx_valid & ~full;
  // 16*(br+1)-1 is simply br followed by four ones, so it never overflows 12 bits
  assign bit_end = (width_cnt_q == {br_q, 4'hF});
  assign pop     = cfg_en & ~empty &
                   ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    width_cnt_d = width_cnt_q + 12'd1;
    bit_idx_d   = bit_idx_q;
    br_d        = br_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    tx_done_d   = 1'b0;
    uart_tx_d   = 1'b1;
    case (state_q)
      S_IDLE:  width_cnt_d = '0;
      S_START: if (bit_end) begin
        state_d     = S_DATA;
        width_cnt_d = '0;
      end
      S_DATA: if (bit_end) begin
        width_cnt_d = '0;
        shift_d     = {1'b0, shift_q[7:1]};
        bit_idx_d   = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) begin
        state_d     = S_STOP;
        width_cnt_d = '0;
      end
      S_STOP: if (bit_end) begin
        state_d     = S_IDLE;
        width_cnt_d = '0;
        tx_done_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A pop in the last STOP cycle overrides the return to IDLE (back-to-back frames)
    if (pop) begin
      state_d     = S_START;
      width_cnt_d = '0;
      bit_idx_d   = '0;
      shift_d     = mem_q[rd_ptr_q];
      br_d        = cfg_br;
      par_en_d    = cfg_parity_en;
      par_bit_d   = (^mem_q[rd_ptr_q]) ^ cfg_parity_odd;
    end
    case (state_d)
      S_START:  uart_tx_d = 1'b0;
      S_DATA:   uart_tx_d = shift_d[0];
      S_PARITY: uart_tx_d = par_bit_d;
      default:  uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      width_cnt_q <= '0;
      bit_idx_q   <= '0;
      br_q        <= '0;
      par_en_q    <= 1'b0;
      uart_tx_q   <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      width_cnt_q <= width_cnt_d;
      bit_idx_q   <= bit_idx_d;
      br_q        <= br_d;
      par_en_q    <= par_en_d;
      uart_tx_q   <= uart_tx_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Payload storage carries no reset; the pointers and level define what is valid
  always_ff @(posedge pclk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx_ready   = ~full;
  assign uart_tx    = uart_tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign fifo_level = level_q;

endmodule
